kernel_load: RTL and testbench

//  Write-side producer for the kernel memory. Packs a narrow host/DMA stream into

---
 rtl/kernel_load.sv | 120 ++++++++++++
 tb/tb_kernel_load.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_load.sv
// kernel_load: packs a narrow kernel stream into wide memory words and opens the write window.
// Optional KERNEL_LOAD_STATS_EN adds a saturating count of accepted memory words.
module kernel_load #(
    parameter int GROUP_NB   = 4,
    parameter int KER_WIDTH  = 16,
    parameter int DEPTH_NB   = 16,
    parameter int STR_WIDTH  = 64,
    parameter int MEM_AWIDTH = 16,
    localparam int WIDE      = GROUP_NB * KER_WIDTH * DEPTH_NB
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MEM_AWIDTH-1:0] cfg_len,
    input  logic                  cfg_val,
    output logic                  cfg_rdy,
    input  logic [STR_WIDTH-1:0]  str_data,
    input  logic                  str_val,
    output logic                  str_rdy,
    output logic [MEM_AWIDTH-1:0] wr_cfg_end,
    output logic                  wr_cfg_set,
    output logic [WIDE-1:0]       wr_data,
    output logic                  wr_data_val,
    input  logic                  wr_data_rdy,
`ifdef KERNEL_LOAD_STATS_EN
    output logic [31:0]           stat_words,
`endif
    output logic                  busy
);
    localparam int BEATS = WIDE / STR_WIDTH;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, OPEN, LOAD, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [MEM_AWIDTH-1:0] end_ptr_q, end_ptr_d;
    logic [MEM_AWIDTH-1:0] len_q, len_d;
    logic [MEM_AWIDTH-1:0] word_q, word_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [WIDE-1:0]       pack_q, pack_d;
    logic [WIDE-1:0]       out_q, out_d;
    logic                  val_q, val_d;
    logic                  last;

    assign last        = beat_q == BW'(BEATS - 1);
    assign cfg_rdy     = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign wr_cfg_set  = state_q == OPEN;
    assign wr_cfg_end  = end_ptr_q;
    assign wr_data     = out_q;
    assign wr_data_val = val_q;
    // The final beat of a word is refused only while the previous word is stuck in the out reg.
    assign str_rdy     = state_q == LOAD && !(last && val_q && !wr_data_rdy);

    always_comb begin
        state_d   = state_q;
        end_ptr_d = end_ptr_q;
        len_d     = len_q;
        word_d    = word_q;
        beat_d    = beat_q;
        pack_d    = pack_q;
        out_d     = out_q;
        val_d     = val_q && !wr_data_rdy;
        unique case (state_q)
            IDLE: if (cfg_val) begin
                len_d     = cfg_len;
                end_ptr_d = end_ptr_q + cfg_len;
                word_d    = '0;
                beat_d    = '0;
                state_d   = OPEN;
            end
            OPEN: state_d = LOAD;
            LOAD: if (str_val && str_rdy) begin
                pack_d[beat_q*STR_WIDTH +: STR_WIDTH] = str_data;
                beat_d = last ? '0 : beat_q + 1'b1;
                if (last) begin
                    out_d  = pack_d;
                    val_d  = 1'b1;
                    word_d = word_q + 1'b1;
                    state_d = (word_d == len_q) ? DRAIN : LOAD;
                end
            end
            DRAIN: state_d = (!val_q || wr_data_rdy) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            end_ptr_q <= '0;
            len_q     <= '0;
            word_q    <= '0;
            beat_q    <= '0;
            pack_q    <= '0;
            out_q     <= '0;
            val_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            end_ptr_q <= end_ptr_d;
            len_q     <= len_d;
            word_q    <= word_d;
            beat_q    <= beat_d;
            pack_q    <= pack_d;
            out_q     <= out_d;
            val_q     <= val_d;
        end
    end

`ifdef KERNEL_LOAD_STATS_EN
    logic [31:0] stat_q, stat_d;

    assign stat_d     = stat_q + ((val_q && wr_data_rdy && stat_q != 32'hFFFF_FFFF) ? 32'd1 : 32'd0);
    assign stat_words = stat_q;

    always_ff @(posedge clk) begin
        if (rst) stat_q <= '0;
        else     stat_q <= stat_d;
    end
`endif
endmodule

// File: tb/tb_kernel_load.sv
// tb_kernel_load: directed bench for kernel_load, plus a narrow-address instance for pointer wrap.
module tb_kernel_load;
    localparam int W = 1024;
    localparam int S = 64;
    localparam int A = 16;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic [A-1:0] cfg_len = '0;
    logic         cfg_val = 0;
    logic         cfg_rdy;
    logic [S-1:0] str_data = '0;
    logic         str_val = 0;
    logic         str_rdy;
    logic [A-1:0] wr_cfg_end;
    logic         wr_cfg_set;
    logic [W-1:0] wr_data;
    logic         wr_data_val;
    logic         wr_data_rdy = 1;
    logic         busy;
`ifdef KERNEL_LOAD_STATS_EN
    logic [31:0]  stat_words;
`endif

    logic [3:0]   cfg_len_w = '0;
    logic         cfg_val_w = 0;
    logic         cfg_rdy_w;
    logic         str_rdy_w;
    logic [3:0]   wr_cfg_end_w;
    logic         wr_cfg_set_w;
    logic [W-1:0] wr_data_w;
    logic         wr_data_val_w;
    logic         busy_w;

    kernel_load dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
        .str_data(str_data), .str_val(str_val), .str_rdy(str_rdy),
        .wr_cfg_end(wr_cfg_end), .wr_cfg_set(wr_cfg_set), .wr_data(wr_data),
        .wr_data_val(wr_data_val), .wr_data_rdy(wr_data_rdy),
`ifdef KERNEL_LOAD_STATS_EN
        .stat_words(stat_words),
`endif
        .busy(busy)
    );

    // One beat per word and a 4-bit address keep the wrap check short.
    kernel_load #(.STR_WIDTH(1024), .MEM_AWIDTH(4)) dut_w (
        .clk(clk), .rst(rst), .cfg_len(cfg_len_w), .cfg_val(cfg_val_w), .cfg_rdy(cfg_rdy_w),
        .str_data({W{1'b1}}), .str_val(1'b1), .str_rdy(str_rdy_w),
        .wr_cfg_end(wr_cfg_end_w), .wr_cfg_set(wr_cfg_set_w), .wr_data(wr_data_w),
        .wr_data_val(wr_data_val_w), .wr_data_rdy(1'b1),
`ifdef KERNEL_LOAD_STATS_EN
        .stat_words(),
`endif
        .busy(busy_w)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] words[$];
    logic [3:0]   ends_w[$];
    int           set_cnt = 0;
    logic [A-1:0] last_end = '0;

    // Sampled just before the rising edge, after the drivers have settled.
    always @(negedge clk) begin
        #3;
        if (wr_data_val && wr_data_rdy) words.push_back(wr_data);
        if (wr_cfg_set) begin
            set_cnt++;
            last_end = wr_cfg_end;
        end
        if (wr_cfg_set_w) ends_w.push_back(wr_cfg_end_w);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            str_val  = 1;
            str_data = S'(base + i);
            #1;
            while (!str_rdy && k < 200) begin
                @(negedge clk);
                #2;
                k++;
            end
            if (!str_rdy) begin
                chk("str_rdy_timeout", {63'd0, str_rdy}, 64'd1);
                str_val = 0;
                return;
            end
            tick();
        end
        str_val = 0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!cfg_rdy && k < 400) begin
            tick();
            k++;
        end
        chk(tag, {63'd0, cfg_rdy}, 64'd1);
    endtask

    task automatic do_load(input int len, input int base);
        tick();
        cfg_len = A'(len);
        cfg_val = 1;
        tick();
        cfg_val = 0;
        send(base, len * 16);
        wait_idle("load_idle");
    endtask

    task automatic do_load_w(input int len);
        int k = 0;
        tick();
        cfg_len_w = 4'(len);
        cfg_val_w = 1;
        tick();
        cfg_val_w = 0;
        while (!cfg_rdy_w && k < 100) begin
            tick();
            k++;
        end
        chk("wrap_idle", {63'd0, cfg_rdy_w}, 64'd1);
    endtask

    initial begin
        logic [W-1:0] snap;
        logic stable;
        logic anyval;

        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("rst_cfg_rdy", {63'd0, cfg_rdy}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_wr_val", {63'd0, wr_data_val}, 64'd0);
        chk("rst_cfg_set", {63'd0, wr_cfg_set}, 64'd0);
        chk("rst_cfg_end", 64'(wr_cfg_end), 64'd0);
        chk("rst_str_rdy", {63'd0, str_rdy}, 64'd0);

        // Single load of two words from beats 0..31
        words.delete();
        set_cnt = 0;
        do_load(2, 0);
        chk("single_sets", 64'(set_cnt), 64'd1);
        chk("single_end", 64'(last_end), 64'd2);
        chk("single_nwords", 64'(words.size()), 64'd2);
        chk("w0_lo", words[0][63:0], 64'd0);
        chk("w0_hi", words[0][1023:960], 64'd15);
        chk("w1_lo", words[1][63:0], 64'd16);
        chk("w1_hi", words[1][1023:960], 64'd31);
        chk("single_busy", {63'd0, busy}, 64'd0);

        // Backpressure: the 32nd beat must stall while word0 sits unaccepted
        words.delete();
        wr_data_rdy = 0;
        tick();
        cfg_len = 3;
        cfg_val = 1;
        tick();
        cfg_val = 0;
        send(100, 31);
        str_val  = 1;
        str_data = 64'd131;
        #1;
        chk("bp_str_rdy", {63'd0, str_rdy}, 64'd0);
        chk("bp_val", {63'd0, wr_data_val}, 64'd1);
        snap = wr_data;
        stable = 1;
        repeat (40) begin
            tick();
            if (wr_data !== snap || !wr_data_val || str_rdy) stable = 0;
        end
        chk("bp_stable", {63'd0, stable}, 64'd1);
        chk("bp_snap_lo", snap[63:0], 64'd100);
        wr_data_rdy = 1;
        send(131, 17);
        wait_idle("bp_idle");
        chk("bp_end", 64'(last_end), 64'd5);
        chk("bp_nwords", 64'(words.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_w%0d_lo", k), words[k][63:0], 64'(100 + 16 * k));
            chk($sformatf("bp_w%0d_hi", k), words[k][1023:960], 64'(115 + 16 * k));
        end

        // Pointer wrap on the 4-bit instance
        ends_w.delete();
        do_load_w(15);
        do_load_w(3);
        chk("wrap_n", 64'(ends_w.size()), 64'd2);
        chk("wrap_e0", ends_w.size() > 0 ? 64'(ends_w[0]) : '1, 64'd15);
        chk("wrap_e1", ends_w.size() > 1 ? 64'(ends_w[1]) : '1, 64'd2);

        // Reset in the middle of word0
        words.delete();
        tick();
        cfg_len = 1;
        cfg_val = 1;
        tick();
        cfg_val = 0;
        send(500, 5);
        rst = 1;
        tick();
        tick();
        rst = 0;
        anyval = 0;
        repeat (5) begin
            tick();
            anyval = anyval | wr_data_val;
        end
        chk("mid_noval", {63'd0, anyval}, 64'd0);
        chk("mid_nwords", 64'(words.size()), 64'd0);
        chk("mid_idle", {63'd0, cfg_rdy}, 64'd1);
        chk("mid_end", 64'(wr_cfg_end), 64'd0);
        do_load(1, 700);
        chk("mid_nwords2", 64'(words.size()), 64'd1);
        chk("mid_w_lo", words[0][63:0], 64'd700);
        chk("mid_w_b5", words[0][383:320], 64'd705);
        chk("mid_w_hi", words[0][1023:960], 64'd715);
        chk("mid_end2", 64'(last_end), 64'd1);

`ifdef KERNEL_LOAD_STATS_EN
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("stat_rst", 64'(stat_words), 64'd0);
        do_load(1, 1000);
        do_load(2, 2000);
        do_load(3, 3000);
        chk("stat_words", 64'(stat_words), 64'd6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
